modred_arbiter: RTL and testbench

Shares one barrett_reduction engine (start/done handshake, 4 compute cycles + 1 finish cycle) among NUM_REQ requesters.
- Owns the modulus configuration register.
- Grants requesters round-robin and sequences one reduction at a time.
- Returns each result tagged with the requester index over a valid/ready response channel.
- Sits between NTT/pointwise-multiply producers and the reduction datapath.

---
 rtl/modred_pkg.sv | 19 +
 rtl/modred_rr_pick.sv | 31 +++
 rtl/modred_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_modred_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// Shared types and constants for the modular-reduction arbiter slice.
package modred_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } modred_state_e;

   localparam int unsigned DefDataWidth = 48;
   localparam int unsigned DefQWidth    = 23;

   // Common moduli used by the lattice-crypto producers
   localparam int unsigned Q_DILITHIUM = 8380417;
   localparam int unsigned Q_KYBER     = 3329;

endpackage

// File: rtl/modred_rr_pick.sv
// Combinational round-robin picker: first asserted valid bit strictly after
// rr_ptr_i (wrapping) wins. Produces a one-hot grant and its encoded index.
module modred_rr_pick #(
   parameter int unsigned NumReq  = 4,
   parameter int unsigned IdWidth = 2
) (
   input  logic [NumReq-1:0]  valid_i,
   input  logic [IdWidth-1:0] rr_ptr_i,
   output logic [NumReq-1:0]  grant_o,
   output logic [IdWidth-1:0] idx_o,
   output logic               any_o
);

   // Scan from rr_ptr+1 around to rr_ptr itself; first hit wins
   always_comb begin
      logic [IdWidth-1:0] cand;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         cand = IdWidth'((32'(rr_ptr_i) + off) % NumReq);
         if (!any_o && valid_i[cand]) begin
            any_o         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/modred_arbiter.sv
// Round-robin arbiter sharing one Barrett reduction engine among NUM_REQ
// requesters. Owns the modulus register, issues one reduction at a time and
// returns tagged results over a valid/ready channel.
// Optional engine watchdog: define MODRED_ARB_TIMEOUT_EN.
module modred_arbiter
   import modred_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = DefDataWidth,
   parameter int unsigned Q_WIDTH        = DefQWidth,
   parameter int unsigned ID_WIDTH       = 2,
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          q_we,
   input  logic [Q_WIDTH-1:0]            q_wdata,
   output logic                          q_wready,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [Q_WIDTH-1:0]            rsp_data,
   output logic                          rsp_err,
   output logic                          eng_start,
   output logic [DATA_WIDTH-1:0]         eng_data_in,
   output logic [Q_WIDTH-1:0]            eng_q,
   input  logic                          eng_done,
   input  logic [Q_WIDTH-1:0]            eng_data_out
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ || TIMEOUT_CYCLES < 1)
   begin : g_bad_param
      $error("modred_arbiter: invalid parameter set");
   end

   modred_state_e         state_q, state_d;
   logic [Q_WIDTH-1:0]    q_reg_q, q_reg_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] op_q, op_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
   logic [Q_WIDTH-1:0]    rsp_data_q, rsp_data_d;

   logic [DATA_WIDTH-1:0] req_op [NUM_REQ];
   logic [NUM_REQ-1:0]    pick_grant;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic                  pick_any;
   logic                  grant_ok;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_op[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   modred_rr_pick #(
      .NumReq  (NUM_REQ),
      .IdWidth (ID_WIDTH)
   ) u_pick (
      .valid_i  (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (pick_grant),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   // A modulus write takes priority over a grant; zero modulus blocks all grants
   assign grant_ok  = (state_q == StIdle) && (q_reg_q != '0) && !q_we && pick_any;
   assign req_ready = grant_ok ? pick_grant : '0;
   assign q_wready  = (state_q == StIdle);

   assign eng_start   = (state_q == StIssue);
   assign eng_data_in = op_q;
   assign eng_q       = q_reg_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;

`ifdef MODRED_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rsp_err_q, rsp_err_d;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Next-state, modulus, operand and response register logic
   always_comb begin
      state_d     = state_q;
      q_reg_d     = q_reg_q;
      rr_ptr_d    = rr_ptr_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
`ifdef MODRED_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (q_we) begin
               q_reg_d = q_wdata;
            end else if (grant_ok) begin
               op_d     = req_op[pick_idx];
               rr_ptr_d = pick_idx;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef MODRED_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StWait: begin
            if (eng_done) begin
               rsp_data_d  = eng_data_out;
               rsp_id_d    = rr_ptr_q;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
`ifdef MODRED_ARB_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d  = '0;
               rsp_id_d    = rr_ptr_q;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
`ifdef MODRED_ARB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         q_reg_q     <= '0;
         rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         q_reg_q     <= q_reg_d;
         rr_ptr_q    <= rr_ptr_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef MODRED_ARB_TIMEOUT_EN
   // Watchdog counter and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_modred_arbiter.sv
// Directed self-checking bench for modred_arbiter with a behavioural
// reduction engine (6 cycles from start to done, result = operand mod q).
module tb_modred_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 48;
   localparam int unsigned QW = 23;
   localparam int unsigned IW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               q_we = 1'b0;
   logic [QW-1:0]      q_wdata = '0;
   logic               q_wready;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*DW-1:0]   req_data = '0;
   logic [NR-1:0]      req_ready;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [IW-1:0]      rsp_id;
   logic [QW-1:0]      rsp_data;
   logic               rsp_err;
   logic               eng_start;
   logic [DW-1:0]      eng_data_in;
   logic [QW-1:0]      eng_q;
   logic               eng_done;
   logic [QW-1:0]      eng_data_out;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;
   bit eng_hang = 1'b0;
   logic [2:0] eng_cnt;
   logic [QW-1:0] eng_res;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   modred_arbiter #(
      .NUM_REQ        (NR),
      .DATA_WIDTH     (DW),
      .Q_WIDTH        (QW),
      .ID_WIDTH       (IW),
      .TIMEOUT_CYCLES (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .q_we         (q_we),
      .q_wdata      (q_wdata),
      .q_wready     (q_wready),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .eng_start    (eng_start),
      .eng_data_in  (eng_data_in),
      .eng_q        (eng_q),
      .eng_done     (eng_done),
      .eng_data_out (eng_data_out)
   );

   // Engine model: done pulses 6 cycles after the start pulse
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_cnt <= '0;
      end else if (eng_start) begin
         eng_cnt <= 3'd6;
         eng_res <= QW'(eng_data_in % DW'(eng_q));
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1'b1;
      end
   end
   assign eng_done     = (eng_cnt == 3'd1) && !eng_hang;
   assign eng_data_out = eng_done ? eng_res : '0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      q_we = 1'b0; req_valid = '0; rsp_ready = 1'b0; eng_hang = 1'b0; req_data = '0;
      rst_n = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic write_q(input logic [QW-1:0] v);
      q_we = 1'b1; q_wdata = v;
      tick;
      q_we = 1'b0;
      #1;
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick;
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_eng_start got=%b want=0", eng_start); end
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      checks++; if (rsp_data !== 23'd0) begin failures++; $display("FAIL reset_rsp_data got=%0d want=0", rsp_data); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      checks++; if (eng_data_in !== 48'd0) begin failures++; $display("FAIL reset_eng_data_in got=%0d want=0", eng_data_in); end
      checks++; if (eng_q !== 23'd0) begin failures++; $display("FAIL reset_eng_q got=%0d want=0", eng_q); end
      checks++; if (q_wready !== 1'b1) begin failures++; $display("FAIL reset_q_wready got=%b want=1", q_wready); end
      do_reset;
   endtask

   task automatic test_q_zero;
      do_reset;
      req_valid = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL q_zero_no_grant cyc=%0d req_ready=%b eng_start=%b want 0000/0", k, req_ready, eng_start);
         end
         tick;
      end
      req_valid = '0;
   endtask

   task automatic test_single;
      do_reset;
      write_q(23'd3329);
      // Modulus write collides with a pending request: write wins, no grant
      req_valid = 4'b0100;
      req_data[2*DW +: DW] = 48'd25141256;
      q_we = 1'b1; q_wdata = 23'd8380417;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL collide_ready got=%b want=0000", req_ready); end
      tick;
      q_we = 1'b0;
      #1;
      checks++; if (eng_q !== 23'd8380417) begin failures++; $display("FAIL q_written got=%0d want=8380417", eng_q); end
      checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL collide_no_start got=%b want=0", eng_start); end
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b want=0100", req_ready); end
      tick; // cycle 1
      req_valid = '0;
      checks++; if (eng_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b want=1", eng_start); end
      checks++; if (eng_data_in !== 48'd25141256) begin failures++; $display("FAIL single_operand got=%0d want=25141256", eng_data_in); end
      checks++; if (q_wready !== 1'b0) begin failures++; $display("FAIL busy_q_wready got=%b want=0", q_wready); end
      repeat (6) tick; // cycle 7
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", rsp_valid); end
      tick; // cycle 8
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid_c8 got=%b want=1", rsp_valid); end
      checks++; if (rsp_data !== 23'd5) begin failures++; $display("FAIL single_data got=%0d want=5", rsp_data); end
      checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d want=2", rsp_id); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", rsp_err); end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_release got=%b want=0", rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic [DW-1:0] dat [NR];
      logic [QW-1:0] exp_res [NR];
      int unsigned last_cyc;
      bit ok;
      dat = '{48'd100, 48'd3430, 48'd6660, 48'd13319};
      exp_res = '{23'd100, 23'd101, 23'd2, 23'd3};
      last_cyc = 0;
      do_reset;
      write_q(23'd3329);
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat[i];
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_rsp(ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL rr_timeout n=%0d got=no_rsp want=rsp", n);
         end else begin
            if (rsp_id !== IW'(n % NR) || rsp_data !== exp_res[n % NR]) begin
               failures++;
               $display("FAIL rr_order n=%0d id=%0d data=%0d want id=%0d data=%0d",
                        n, rsp_id, rsp_data, n % NR, exp_res[n % NR]);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last_cyc != 9) begin
                  failures++;
                  $display("FAIL rr_throughput n=%0d got=%0d want=9", n, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
         end
      end
      req_valid = '0;
      tick;
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      bit ok;
      do_reset;
      write_q(23'd3329);
      req_data[1*DW +: DW] = 48'd16662;
      req_valid = 4'b0010;
      wait_rsp(ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_rsp got=no_rsp want=rsp"); end
      req_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 23'd17 ||
             req_ready !== 4'b0000 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold k=%0d v=%b id=%0d data=%0d rdy=%b st=%b want 1/1/17/0000/0",
                     k, rsp_valid, rsp_id, rsp_data, req_ready, eng_start);
         end
         tick;
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      tick;
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", rsp_valid); end
      tick;
      checks++;
      if (rsp_valid !== 1'b0 || eng_start !== 1'b0) begin
         failures++;
         $display("FAIL bp_single_accept v=%b st=%b want 0/0", rsp_valid, eng_start);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      write_q(23'd8380417);
      req_data[0 +: DW] = 48'd100;
      req_valid = 4'b0001;
      tick; // issue
      req_valid = '0;
      tick; tick; // waiting on engine
      rst_n = 1'b0;
      #1;
      checks++;
      if (eng_start !== 1'b0 || rsp_valid !== 1'b0 || eng_q !== 23'd0 ||
          eng_data_in !== 48'd0 || q_wready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset st=%b v=%b q=%0d din=%0d wr=%b want 0/0/0/0/1",
                  eng_start, rsp_valid, eng_q, eng_data_in, q_wready);
      end
      tick;
      rst_n = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || eng_start !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle k=%0d rdy=%b st=%b v=%b want 0000/0/0",
                     k, req_ready, eng_start, rsp_valid);
         end
         tick;
      end
      write_q(23'd3329);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_grant got=%b want=0001", req_ready); end
      req_valid = '0;
      tick;
   endtask

`ifdef MODRED_ARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset;
      write_q(23'd3329);
      eng_hang = 1'b1;
      req_data[0 +: DW] = 48'd5;
      req_valid = 4'b0001;
      tick; // cycle 1
      req_valid = '0;
      repeat (32) tick; // cycle 33
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_early got=%b want=0", rsp_valid); end
      tick; // cycle 34
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 23'd0) begin
         failures++;
         $display("FAIL to_resp v=%b err=%b data=%0d want 1/1/0", rsp_valid, rsp_err, rsp_data);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL to_clear v=%b err=%b want 0/0", rsp_valid, rsp_err);
      end
      eng_hang = 1'b0;
   endtask
`endif

   initial begin
      tick;
      test_reset;
      test_q_zero;
      test_single;
      test_round_robin;
      test_backpressure;
      test_reset_mid;
`ifdef MODRED_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
